main_sprite_core: RTL and testbench

Self-contained sprite engine for the two-car game datapath. After reset it procedurally generates a 60x60 RGB565 car sprite and writes it into external SRAM. While writing, it builds 60x60 opacity maps for car1 (upright) and car2 (rotated). It then reads the sprite back and streams it as RGB888 pixels to the renderer/VGA path.

---
 rtl/main_sprite_pkg.sv | 19 +
 rtl/main_sprite_core_sprite_gen.sv | 19 +
 rtl/main_sprite_core.sv | 124 ++++++++++++
 tb/tb_main_sprite_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/main_sprite_pkg.sv
// Shared constants, state encoding and colour conversion for the sprite engine.
package main_sprite_pkg;

    localparam int          SPRITE_DIM  = 60;
    localparam int          PIX_COUNT   = SPRITE_DIM * SPRITE_DIM;
    localparam logic [19:0] SPRITE_BASE = 20'h00000;

    localparam logic [15:0] BODY  = 16'hF800;
    localparam logic [15:0] GLASS = 16'h001F;
    localparam logic [15:0] CLEAR = 16'h0000;

    typedef enum logic [1:0] {S_RESET, S_WRITE, S_READ, S_DONE} state_t;

    // Low bits are filled by replicating the top bits so full-scale maps to 8'hFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/main_sprite_core_sprite_gen.sv
// Procedural car sprite: maps a (row, col) position to its RGB565 pixel.
module sprite_gen
    import main_sprite_pkg::*;
(
    input  logic [5:0]  i_row,
    input  logic [5:0]  i_col,
    output logic [15:0] o_pix
);

    always_comb begin
        o_pix = CLEAR;
        if (i_row >= 6'd10 && i_row <= 6'd49 && i_col >= 6'd20 && i_col <= 6'd39)
            o_pix = BODY;
        // Windshield overrides the body inside its rectangle.
        if (i_row >= 6'd15 && i_row <= 6'd19 && i_col >= 6'd22 && i_col <= 6'd37)
            o_pix = GLASS;
    end

endmodule

// File: rtl/main_sprite_core.sv
// Sprite engine: writes the generated sprite to SRAM while building opacity maps,
// then streams it back as RGB888. Define CAR2_ROTATE_EN to rotate the car2 map 90 deg CW.
module main_sprite_core
    import main_sprite_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [19:0] o_SRAM_ADDR,
    inout  wire  [15:0] io_SRAM_DQ,
    output logic        o_SRAM_WE_N,
    output logic [23:0] o_RGB,
    output logic        o_RGB_valid,
    output logic        o_render_clk,
    output logic [0:SPRITE_DIM-1][0:SPRITE_DIM-1] o_car1_opacity_map,
    output logic [0:SPRITE_DIM-1][0:SPRITE_DIM-1] o_car2_opacity_map
);

    state_t      r_state;
    logic [5:0]  r_row;
    logic [5:0]  r_col;
    logic [19:0] r_addr;
    logic        r_we_n;
    logic        r_rd_v1;
    logic [23:0] r_rgb;
    logic        r_rgb_valid;
    logic        r_render_clk;

    logic [15:0] w_pix;
    logic        w_opaque;
    logic        w_last;
    logic [5:0]  w_row_nxt;
    logic [5:0]  w_col_nxt;
    logic [19:0] w_addr_nxt;
    logic [5:0]  w_map2_row;
    logic [5:0]  w_map2_col;

    sprite_gen u_gen (
        .i_row (r_row),
        .i_col (r_col),
        .o_pix (w_pix)
    );

    assign w_opaque   = (w_pix != CLEAR);
    assign w_last     = (r_row == 6'(SPRITE_DIM - 1)) && (r_col == 6'(SPRITE_DIM - 1));
    assign w_col_nxt  = (r_col == 6'(SPRITE_DIM - 1)) ? 6'd0 : r_col + 6'd1;
    assign w_row_nxt  = (r_col == 6'(SPRITE_DIM - 1)) ? r_row + 6'd1 : r_row;
    assign w_addr_nxt = SPRITE_BASE + ({14'd0, w_row_nxt} * 20'd60) + {14'd0, w_col_nxt};

`ifdef CAR2_ROTATE_EN
    // Pixel (r,c) lands at map2[c][59-r] under a clockwise quarter turn.
    assign w_map2_row = r_col;
    assign w_map2_col = 6'(SPRITE_DIM - 1) - r_row;
`else
    assign w_map2_row = r_row;
    assign w_map2_col = r_col;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state            <= S_RESET;
            r_row              <= 6'd0;
            r_col              <= 6'd0;
            r_addr             <= 20'd0;
            r_we_n             <= 1'b1;
            r_rd_v1            <= 1'b0;
            r_rgb              <= 24'd0;
            r_rgb_valid        <= 1'b0;
            o_car1_opacity_map <= '0;
            o_car2_opacity_map <= '0;
        end else begin
            // SRAM data for the address issued last cycle is on the bus now.
            r_rd_v1     <= (r_state == S_READ);
            r_rgb_valid <= r_rd_v1;
            r_rgb       <= r_rd_v1 ? rgb565_to_888(io_SRAM_DQ) : 24'd0;
            case (r_state)
                S_RESET: begin
                    r_state <= S_WRITE;
                    r_row   <= 6'd0;
                    r_col   <= 6'd0;
                    r_addr  <= SPRITE_BASE;
                    r_we_n  <= 1'b0;
                end
                S_WRITE: begin
                    o_car1_opacity_map[r_row][r_col]           <= w_opaque;
                    o_car2_opacity_map[w_map2_row][w_map2_col] <= w_opaque;
                    if (w_last) begin
                        r_state <= S_READ;
                        r_row   <= 6'd0;
                        r_col   <= 6'd0;
                        r_addr  <= SPRITE_BASE;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_row  <= w_row_nxt;
                        r_col  <= w_col_nxt;
                        r_addr <= w_addr_nxt;
                    end
                end
                S_READ: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_row  <= w_row_nxt;
                        r_col  <= w_col_nxt;
                        r_addr <= w_addr_nxt;
                    end
                end
                default: r_state <= S_DONE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_render_clk <= 1'b0;
        else       r_render_clk <= ~r_render_clk;
    end

    assign io_SRAM_DQ   = r_we_n ? 16'hzzzz : w_pix;
    assign o_SRAM_ADDR  = r_addr;
    assign o_SRAM_WE_N  = r_we_n;
    assign o_RGB        = r_rgb;
    assign o_RGB_valid  = r_rgb_valid;
    assign o_render_clk = r_render_clk;

endmodule

// File: tb/tb_main_sprite_core.sv
// Self-checking bench for main_sprite_core with a behavioural SRAM and sprite model.
module tb_main_sprite_core;

    logic        clk;
    logic        rst;
    logic [19:0] addr;
    wire  [15:0] dq;
    logic        we_n;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        rclk;
    logic [0:59][0:59] map1;
    logic [0:59][0:59] map2;

    logic [0:59][0:59] exp1;
    logic [0:59][0:59] exp2;

    int n_assert = 0;
    int n_fail   = 0;

    main_sprite_core dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .o_SRAM_ADDR        (addr),
        .io_SRAM_DQ         (dq),
        .o_SRAM_WE_N        (we_n),
        .o_RGB              (rgb),
        .o_RGB_valid        (rgb_valid),
        .o_render_clk       (rclk),
        .o_car1_opacity_map (map1),
        .o_car2_opacity_map (map2)
    );

    // Synchronous SRAM: write at WE_N=0 edge, read data driven for the cycle after the address edge.
    logic [15:0] mem [0:4095];
    logic [19:0] rd_addr;
    logic        rd_en;

    always @(posedge clk) begin
        if (!we_n) mem[addr[11:0]] <= dq;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= 20'd0;
        end else begin
            rd_en   <= we_n;
            rd_addr <= addr;
        end
    end

    assign dq = (rd_en && we_n && !rst) ? mem[rd_addr[11:0]] : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mpix(input int r, input int c);
        if (r >= 15 && r <= 19 && c >= 22 && c <= 37) return 16'h001F;
        if (r >= 10 && r <= 49 && c >= 20 && c <= 39) return 16'hF800;
        return 16'h0000;
    endfunction

    function automatic logic [23:0] mexp(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p) / 2048;
        g6 = (int'(p) / 32) % 64;
        b5 = int'(p) % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return 24'(r8 * 65536 + g8 * 256 + b8);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},  64'(addr), 64'd0);
        chk({tag, "_we_n"},  64'(we_n), 64'd1);
        chk({tag, "_dq"},    {48'd0, dq}, {48'd0, 16'hzzzz});
        chk({tag, "_rgb"},   64'(rgb), 64'd0);
        chk({tag, "_valid"}, 64'(rgb_valid), 64'd0);
        chk({tag, "_rclk"},  64'(rclk), 64'd0);
        chk({tag, "_map1z"}, 64'(map1 === '0), 64'd1);
        chk({tag, "_map2z"}, 64'(map2 === '0), 64'd1);
    endtask

    // Checks n write cycles starting from W0 (first negedge after the first post-release edge).
    task automatic write_phase(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("write_k%0d", k), 64'({rclk, we_n, addr, dq}),
                64'({1'((k + 1) % 2), 1'b0, 20'(k), mpix(k / 60, k % 60)}));
        end
    endtask

    task automatic check_maps(input string tag);
        for (int r = 0; r < 60; r++) begin
            chk($sformatf("%s_map1_row%0d", tag, r), 64'(map1[r]), 64'(exp1[r]));
            chk($sformatf("%s_map2_row%0d", tag, r), 64'(map2[r]), 64'(exp2[r]));
        end
    endtask

    initial begin
        int nvalid, nred, nblue, rr, cc, m;
        for (int r = 0; r < 60; r++)
            for (int c = 0; c < 60; c++) begin
                exp1[r][c] = (mpix(r, c) != 16'h0000);
`ifdef CAR2_ROTATE_EN
                exp2[r][c] = (mpix(59 - c, r) != 16'h0000);
`else
                exp2[r][c] = (mpix(r, c) != 16'h0000);
`endif
            end

        // Run 1: full uninterrupted sequence.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("rst1");
        rst = 1'b0;
        write_phase(3600);

        nvalid = 0; nred = 0; nblue = 0;
        for (int j = 0; j < 3606; j++) begin
            @(negedge clk);
            chk($sformatf("rclk_r%0d", j), 64'(rclk), 64'((j + 1) % 2));
            if (j == 0) begin
                chk("m1_10_20", 64'(map1[10][20]), 64'd1);
                chk("m1_49_39", 64'(map1[49][39]), 64'd1);
                chk("m1_9_20",  64'(map1[9][20]),  64'd0);
                chk("m1_10_40", 64'(map1[10][40]), 64'd0);
                chk("m1_0_0",   64'(map1[0][0]),   64'd0);
`ifdef CAR2_ROTATE_EN
                chk("m2_20_49", 64'(map2[20][49]), 64'd1);
                chk("m2_39_10", 64'(map2[39][10]), 64'd1);
                chk("m2_20_50", 64'(map2[20][50]), 64'd0);
                chk("m2_19_30", 64'(map2[19][30]), 64'd0);
`else
                chk("m2_eq_m1", 64'(map2 === map1), 64'd1);
`endif
            end
            if (j < 3600)
                chk($sformatf("read_addr%0d", j), 64'({we_n, addr}), 64'({1'b1, 20'(j)}));
            chk($sformatf("valid_r%0d", j), 64'(rgb_valid), 64'(j >= 2 && j < 3602));
            if (j >= 2 && j < 3602)
                chk($sformatf("pix%0d", j - 2), 64'(rgb),
                    64'(mexp(mpix((j - 2) / 60, (j - 2) % 60))));
            if (rgb_valid === 1'b1) begin
                nvalid++;
                if (rgb === 24'hFF0000) nred++;
                if (rgb === 24'h0000FF) nblue++;
            end
        end
        chk("n_valid", 64'(nvalid), 64'd3600);
        chk("n_red",   64'(nred),   64'd720);
        chk("n_blue",  64'(nblue),  64'd80);
        chk("done_rgb", 64'(rgb), 64'd0);
        check_maps("run1");
        for (int i = 0; i < 40; i++) begin
            rr = int'($urandom_range(0, 59));
            cc = int'($urandom_range(0, 59));
            chk($sformatf("spot1_%0d_%0d", rr, cc), 64'({map1[rr][cc], map2[rr][cc]}),
                64'({exp1[rr][cc], exp2[rr][cc]}));
        end

        // Run 2: reset at W1000, restart, maps must rebuild identically.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        write_phase(1000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("midw");
        repeat (2) begin
            @(negedge clk);
            chk("midw_hold_rclk", 64'(rclk), 64'd0);
        end
        rst = 1'b0;
        write_phase(3600);
        @(negedge clk);
        chk("run2_we_rise", 64'(we_n), 64'd1);
        check_maps("run2");

        // Run 3: reset at a random point in READ, then restart from address 0.
        m = int'($urandom_range(5, 3000));
        repeat (m) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset("midr");
        @(negedge clk);
        rst = 1'b0;
        write_phase(64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
